// File: rtl/wordle_pkg.sv
// Shared definitions for the guess writer: slot geometry, color codes and
// the row-editing FSM state enumeration.
package wordle_pkg;

  localparam int WORD_LEN    = 5;  // letters per row
  localparam int MAX_GUESSES = 6;  // rows before the game locks
  localparam int LETTER_W    = 5;  // letter code width (0='A' .. 25='Z')
  localparam int SLOT_W      = 7;  // {color[1:0], letter[4:0]}
  localparam int COLOR_W     = 2;

  localparam logic [LETTER_W-1:0] LAST_LETTER = 5'd25;

  localparam logic [COLOR_W-1:0] NONE   = 2'b00;  // entered, not yet scored
  localparam logic [COLOR_W-1:0] GREEN  = 2'b01;  // right letter, right place
  localparam logic [COLOR_W-1:0] YELLOW = 2'b10;  // letter elsewhere in word
  localparam logic [COLOR_W-1:0] GRAY   = 2'b11;  // letter absent

  typedef enum logic [1:0] {
    EDIT  = 2'd0,
    SCORE = 2'd1,
    SHOW  = 2'd2,
    LOCK  = 2'd3
  } state_e;

endpackage

// File: rtl/letter_scorer.sv
// Combinational color for one guessed letter against the target word.
// Ports:
//   letter       - guessed letter code
//   index        - position of that letter in the row (0-4)
//   current_word - target word, letter i at [5i+4:5i]
//   color        - GREEN / YELLOW / GRAY
// Each letter is judged on its own: repeated letters are not counted.
module letter_scorer
  import wordle_pkg::*;
(
  input  logic [LETTER_W-1:0]          letter,
  input  logic [2:0]                   index,
  input  logic [WORD_LEN*LETTER_W-1:0] current_word,
  output logic [COLOR_W-1:0]           color
);

  logic hit_same;
  logic hit_other;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves a signal unassigned would infer a latch.
    hit_same  = 1'b0;
    hit_other = 1'b0;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (current_word[i*LETTER_W +: LETTER_W] == letter) begin
        if (index == 3'(i)) hit_same  = 1'b1;
        else                hit_other = 1'b1;
      end
    end
    if (hit_same)       color = GREEN;
    else if (hit_other) color = YELLOW;
    else                color = GRAY;
  end

endmodule

// File: rtl/guess_writer.sv
// Row editor and scorer for a five-letter word game.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   sw            - letter code to enter (26-31 invalid)
//   add/del       - append letter at cursor / remove last letter (pulses)
//   submit        - score the full row (pulse)
//   current_word  - target word, held stable while busy
//   display       - row, slot i at [7i+6:7i] as {color, letter}
//   col           - number of letters entered
//   busy          - scoring in progress (one slot per cycle)
//   done          - one-cycle pulse after the last slot is scored
//   win           - last scored row was all green (sticky until reset)
//   guess_cnt     - completed guesses
module guess_writer
  import wordle_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LETTER_W-1:0]           sw,
  input  logic                          add,
  input  logic                          del,
  input  logic                          submit,
  input  logic [WORD_LEN*LETTER_W-1:0]  current_word,
  output logic [WORD_LEN*SLOT_W-1:0]    display,
  output logic [2:0]                    col,
  output logic                          busy,
  output logic                          done,
  output logic                          win,
  output logic [2:0]                    guess_cnt
);

  state_e                           state_q, state_d;
  logic [WORD_LEN-1:0][SLOT_W-1:0]  disp_q, disp_d;
  logic [2:0]                       col_q, col_d;
  logic [2:0]                       idx_q, idx_d;
  logic                             done_q, done_d;
  logic                             win_q, win_d;
  logic [2:0]                       cnt_q, cnt_d;

  logic [COLOR_W-1:0]               score_color;
  logic                             all_green;

  // A single scorer is time-shared across the row, addressed by idx_q.
  letter_scorer u_scorer (
    .letter       (disp_q[idx_q][LETTER_W-1:0]),
    .index        (idx_q),
    .current_word (current_word),
    .color        (score_color)
  );

  always_comb begin
    state_d   = state_q;
    disp_d    = disp_q;
    col_d     = col_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    win_d     = win_q;
    cnt_d     = cnt_q;
    all_green = 1'b0;

    unique case (state_q)
      EDIT: begin
        // Only the highest-priority asserted event is considered.
        if (submit) begin
          if (col_q == 3'(WORD_LEN)) begin
            state_d = SCORE;
            idx_d   = 3'd0;
          end
        end else if (del) begin
          if (col_q != 3'd0) begin
            disp_d[col_q - 3'd1] = '0;
            col_d                = col_q - 3'd1;
          end
        end else if (add) begin
          if ((col_q < 3'(WORD_LEN)) && (sw <= LAST_LETTER)) begin
            disp_d[col_q] = {NONE, sw};
            col_d         = col_q + 3'd1;
          end
        end
      end

      SCORE: begin
        disp_d[idx_q][SLOT_W-1:LETTER_W] = score_color;
        if (idx_q == 3'(WORD_LEN-1)) begin
          // Earlier slots are already registered; the last one is still
          // on the scorer output this cycle.
          all_green = (score_color == GREEN);
          for (int i = 0; i < WORD_LEN-1; i++) begin
            if (disp_q[i][SLOT_W-1:LETTER_W] != GREEN) all_green = 1'b0;
          end
          done_d  = 1'b1;
          cnt_d   = cnt_q + 3'd1;
          win_d   = all_green;
          state_d = (all_green || (cnt_d == 3'(MAX_GUESSES))) ? LOCK : SHOW;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end

      SHOW: begin
        // Starting a new row: wipe the scored row and take the letter.
        if (add && (sw <= LAST_LETTER)) begin
          disp_d    = '0;
          disp_d[0] = {NONE, sw};
          col_d     = 3'd1;
          state_d   = EDIT;
        end
      end

      LOCK: begin
      end

      default: state_d = EDIT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EDIT;
      disp_q  <= '0;
      col_q   <= 3'd0;
      idx_q   <= 3'd0;
      done_q  <= 1'b0;
      win_q   <= 1'b0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  assign display   = disp_q;
  assign col       = col_q;
  assign busy      = (state_q == SCORE);
  assign done      = done_q;
  assign win       = win_q;
  assign guess_cnt = cnt_q;

endmodule

// File: tb/tb_guess_writer.sv
// Self-checking bench for guess_writer: a table of editing vectors, hand
// sequences for the scoring corner cases, and randomized play checked
// against a row-level reference model.
module tb_guess_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  sw;
  logic        add, del, submit;
  logic [24:0] current_word;
  logic [34:0] display;
  logic [2:0]  col;
  logic        busy, done, win;
  logic [2:0]  guess_cnt;

  guess_writer dut (
    .clk          (clk),
    .rst          (rst),
    .sw           (sw),
    .add          (add),
    .del          (del),
    .submit       (submit),
    .current_word (current_word),
    .display      (display),
    .col          (col),
    .busy         (busy),
    .done         (done),
    .win          (win),
    .guess_cnt    (guess_cnt)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (row level) ----------------
  typedef enum {M_EDIT, M_SCORING, M_SHOW, M_LOCK} mmode_e;
  mmode_e     m_mode;
  int         m_letters[5];
  logic [1:0] m_colors[5];
  logic [1:0] m_row[5];
  int         m_col, m_k, m_cnt;
  bit         m_win, m_done;

  function automatic logic [24:0] pack5(int a, int b, int c, int d, int e);
    return {e[4:0], d[4:0], c[4:0], b[4:0], a[4:0]};
  endfunction

  function automatic logic [34:0] slot(int i, logic [1:0] c, int l);
    logic [34:0] v;
    v = {28'b0, c, l[4:0]};
    return v << (7*i);
  endfunction

  function automatic logic [1:0] ref_color(int letter, int pos, logic [24:0] word);
    if (int'(word[5*pos +: 5]) == letter) return 2'b01;
    for (int j = 0; j < 5; j++)
      if (j != pos && int'(word[5*j +: 5]) == letter) return 2'b10;
    return 2'b11;
  endfunction

  function automatic logic [34:0] exp_display();
    logic [34:0] d = '0;
    for (int i = 0; i < 5; i++) d |= slot(i, m_colors[i], m_letters[i]);
    return d;
  endfunction

  task automatic model_reset();
    m_mode = M_EDIT; m_col = 0; m_k = 0; m_cnt = 0; m_win = 0; m_done = 0;
    for (int i = 0; i < 5; i++) begin m_letters[i] = 0; m_colors[i] = 2'b00; end
  endtask

  task automatic model_step(input bit a, input bit d, input bit s, input int swv);
    m_done = 0;
    case (m_mode)
      M_EDIT: begin
        if (s) begin
          if (m_col == 5) begin
            for (int i = 0; i < 5; i++) m_row[i] = ref_color(m_letters[i], i, current_word);
            m_mode = M_SCORING;
            m_k = 0;
          end
        end else if (d) begin
          if (m_col > 0) begin
            m_col--;
            m_letters[m_col] = 0;
            m_colors[m_col] = 2'b00;
          end
        end else if (a) begin
          if (m_col < 5 && swv <= 25) begin
            m_letters[m_col] = swv;
            m_colors[m_col] = 2'b00;
            m_col++;
          end
        end
      end
      M_SCORING: begin
        m_colors[m_k] = m_row[m_k];
        m_k++;
        if (m_k == 5) begin
          m_done = 1;
          m_cnt++;
          m_win = 1;
          for (int i = 0; i < 5; i++) if (m_row[i] != 2'b01) m_win = 0;
          m_mode = (m_win || m_cnt == 6) ? M_LOCK : M_SHOW;
        end
      end
      M_SHOW: begin
        if (a && swv <= 25) begin
          for (int i = 0; i < 5; i++) begin m_letters[i] = 0; m_colors[i] = 2'b00; end
          m_letters[0] = swv;
          m_col = 1;
          m_mode = M_EDIT;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check("display",   64'(display),   64'(exp_display()));
    check("col",       64'(col),       64'(m_col));
    check("busy",      64'(busy),      64'(m_mode == M_SCORING));
    check("done",      64'(done),      64'(m_done));
    check("win",       64'(win),       64'(m_win));
    check("guess_cnt", 64'(guess_cnt), 64'(m_cnt));
  endtask

  // Inputs change 1ns after a rising edge; outputs are compared there too.
  task automatic step(input bit a, input bit d, input bit s, input int swv);
    add = a; del = d; submit = s; sw = swv[4:0];
    @(posedge clk);
    model_step(a, d, s, swv);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    add = 0; del = 0; submit = 0; sw = '0;
    rst = 1'b1;
    #2;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit         a, d, s;
    int         swv;
    logic [2:0] e_col;
    logic [34:0] e_disp;
  } vec_t;

  vec_t tbl[10];

  localparam int C = 2, R = 17, A = 0, N = 13, E = 4;

  initial begin
    logic [34:0] row_exp;
    int busy_cycles;
    add = 0; del = 0; submit = 0; sw = '0;
    current_word = pack5(C, R, A, N, E);

    // ---- editing table: F A Z, submit short row, deletes, invalid codes ----
    tbl[0] = '{1, 0, 0,  5, 3'd1, slot(0, 2'b00, 5)};
    tbl[1] = '{1, 0, 0,  0, 3'd2, slot(0, 2'b00, 5) | slot(1, 2'b00, 0)};
    tbl[2] = '{1, 0, 0, 25, 3'd3, slot(0, 2'b00, 5) | slot(1, 2'b00, 0) | slot(2, 2'b00, 25)};
    tbl[3] = '{0, 0, 1,  0, 3'd3, slot(0, 2'b00, 5) | slot(1, 2'b00, 0) | slot(2, 2'b00, 25)};
    tbl[4] = '{0, 1, 0,  0, 3'd2, slot(0, 2'b00, 5) | slot(1, 2'b00, 0)};
    tbl[5] = '{0, 1, 0,  0, 3'd1, slot(0, 2'b00, 5)};
    tbl[6] = '{1, 0, 0, 27, 3'd1, slot(0, 2'b00, 5)};
    tbl[7] = '{0, 1, 0,  0, 3'd0, 35'd0};
    tbl[8] = '{0, 1, 0,  0, 3'd0, 35'd0};
    tbl[9] = '{1, 0, 0, 31, 3'd0, 35'd0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].swv);
      check($sformatf("tbl%0d_col", i),     64'(col),     64'(tbl[i].e_col));
      check($sformatf("tbl%0d_display", i), 64'(display), 64'(tbl[i].e_disp));
      check($sformatf("tbl%0d_busy", i),    64'(busy),    64'd0);
    end

    // ---- same-cycle add+del at col=3: only del takes effect ----
    step(1, 0, 0, 1); step(1, 0, 0, 2); step(1, 0, 0, 3);
    step(1, 1, 0, 4);
    check("adddel_col",     64'(col),     64'd2);
    check("adddel_display", 64'(display), 64'(slot(0, 2'b00, 1) | slot(1, 2'b00, 2)));

    // ---- CRANE vs CRANE: win, with adds attempted during scoring ----
    do_reset();
    current_word = pack5(C, R, A, N, E);
    step(1, 0, 0, C); step(1, 0, 0, R); step(1, 0, 0, A); step(1, 0, 0, N); step(1, 0, 0, E);
    step(0, 0, 1, 0);
    busy_cycles = 0;
    for (int t = 0; t < 8 && !done; t++) begin
      if (busy) busy_cycles++;
      check("score_col_hold", 64'(col), 64'd5);
      step(1, 0, 0, 7);
    end
    row_exp = slot(0, 2'b01, C) | slot(1, 2'b01, R) | slot(2, 2'b01, A) |
              slot(3, 2'b01, N) | slot(4, 2'b01, E);
    check("crane_busy_cycles", 64'(busy_cycles), 64'd5);
    check("crane_done",        64'(done),        64'd1);
    check("crane_display",     64'(display),     64'(row_exp));
    check("crane_win",         64'(win),         64'd1);
    check("crane_cnt",         64'(guess_cnt),   64'd1);
    step(1, 0, 0, 3);
    check("lock_done_low", 64'(done),    64'd0);
    check("lock_display",  64'(display), 64'(row_exp));
    check("lock_col",      64'(col),     64'd5);

    // ---- NACRE vs CRANE: yellows then green, SHOW behaviour ----
    do_reset();
    step(1, 0, 0, N); step(1, 0, 0, A); step(1, 0, 0, C); step(1, 0, 0, R); step(1, 0, 0, E);
    step(0, 0, 1, 0);
    repeat (5) step(0, 0, 0, 0);
    row_exp = slot(0, 2'b10, N) | slot(1, 2'b10, A) | slot(2, 2'b10, C) |
              slot(3, 2'b10, R) | slot(4, 2'b01, E);
    check("nacre_display", 64'(display),   64'(row_exp));
    check("nacre_win",     64'(win),       64'd0);
    check("nacre_cnt",     64'(guess_cnt), 64'd1);
    step(0, 1, 0, 0);
    check("show_del_display", 64'(display), 64'(row_exp));
    step(0, 0, 1, 0);
    check("show_submit_busy", 64'(busy), 64'd0);
    step(1, 0, 0, 5);
    check("show_add_col",     64'(col),     64'd1);
    check("show_add_display", 64'(display), 64'(slot(0, 2'b00, 5)));

    // ---- asynchronous reset in the middle of scoring ----
    step(1, 0, 0, 6); step(1, 0, 0, 7); step(1, 0, 0, 8); step(1, 0, 0, 9);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    check("async_display", 64'(display),   64'd0);
    check("async_col",     64'(col),       64'd0);
    check("async_busy",    64'(busy),      64'd0);
    check("async_done",    64'(done),      64'd0);
    check("async_win",     64'(win),       64'd0);
    check("async_cnt",     64'(guess_cnt), 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    // ---- six losing guesses lock the game ----
    do_reset();
    current_word = pack5(C, R, A, N, E);
    for (int g = 0; g < 6; g++) begin
      for (int l = 0; l < 5; l++) step(1, 0, 0, 20 + l);
      step(0, 0, 1, 0);
      repeat (5) step(0, 0, 0, 0);
    end
    check("six_cnt", 64'(guess_cnt), 64'd6);
    check("six_win", 64'(win),       64'd0);
    step(1, 0, 0, 1);
    check("six_lock_col", 64'(col), 64'd5);

    // ---- randomized play against the model ----
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int r;
      int letter;
      if (m_mode == M_LOCK) begin
        current_word = pack5($urandom_range(0, 25), $urandom_range(0, 25),
                             $urandom_range(0, 25), $urandom_range(0, 25),
                             $urandom_range(0, 25));
        do_reset();
      end
      r = $urandom_range(0, 11);
      if (r < 7) begin
        if (($urandom_range(0, 1) == 1) && m_mode != M_SHOW && m_col < 5)
          letter = int'(current_word[5*m_col +: 5]);
        else if (m_mode == M_SHOW && $urandom_range(0, 1) == 1)
          letter = int'(current_word[4:0]);
        else
          letter = $urandom_range(0, 31);
        step(1, 0, 0, letter);
      end else if (r < 8) begin
        step(0, 1, 0, 0);
      end else if (r < 10) begin
        step(0, 0, 1, 0);
      end else begin
        step(0, 0, 0, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/guess_writer.md
GUESS_WRITER -- requirements
Module: guess_writer

Interface
REQ-001 clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 sw  input  5  letter code of the letter to enter (0='A' .. 25='Z'); codes 26-31 are invalid.
REQ-004 add  input  1  one-cycle pulse; appends sw at the cursor.
REQ-005 del  input  1  one-cycle pulse; removes the last entered letter.
REQ-006 submit  input  1  one-cycle pulse; requests scoring of the current row.
REQ-007 current_word  input  25  target word; letter i occupies bits [5i+4:5i].
REQ-008 display  output  35  row word; slot i occupies [7i+6:7i] as {color[1:0], letter[4:0]}.
REQ-009 col  output  3  cursor, equal to the number of letters entered (0-5).
REQ-010 busy  output  1  high while in SCORE.
REQ-011 done  output  1  one-cycle pulse when scoring completes.
REQ-012 win  output  1  high when the last scored row was all green; held until reset.
REQ-013 guess_cnt  output  3  number of completed guesses (0-6).

Function
REQ-014 Color codes shall be: 00 entered/unscored, 01 green (right letter, right position), 10 yellow (letter present at another position), 11 gray (absent).
REQ-015 The FSM shall have states EDIT, SCORE, SHOW and LOCK.
REQ-016 EDIT shall be entered after reset and accept add, del and submit.
REQ-017 In EDIT, when several events occur in the same cycle, priority shall be submit > del > add, and only one event shall take effect per cycle.
REQ-018 add with col<5 and sw<=25 shall write {00,sw} to slot col and increment col; add with col=5 or an invalid sw shall be ignored.
REQ-019 del with col>0 shall clear slot col-1 to 7'b0 and decrement col; del with col=0 shall be ignored.
REQ-020 submit with col=5 shall enter SCORE with the score index at 0; submit with col<5 shall be ignored.
REQ-021 SCORE shall score one slot per cycle, index 0 to 4, writing that slot's color bits; letter bits shall be unchanged.
REQ-022 Per-slot color shall be: green if the letter equals current_word at the same index; else yellow if it equals current_word at any other index; else gray.
REQ-023 Repeated letters shall not be counted; each slot is scored independently.
REQ-024 Scoring latency shall be exactly 5 cycles.
REQ-025 On the cycle after index 4 is written, done shall pulse, guess_cnt shall increment, and win shall be set if all five slots are green.
REQ-026 After scoring, the next state shall be LOCK if win=1 or guess_cnt reaches 6; otherwise it shall be SHOW.
REQ-027 add, del and submit shall be ignored during SCORE.
REQ-028 current_word shall be sampled each SCORE cycle and shall be held stable by the source during SCORE.
REQ-029 SHOW shall hold display unchanged.
REQ-030 In SHOW, add shall clear all slots, write the new letter to slot 0 with col=1, and enter EDIT; del and submit shall be ignored.
REQ-031 LOCK shall ignore all inputs and hold every output until reset.

Reset
REQ-032 Asserting rst, at any time including mid-SCORE, shall immediately force state=EDIT, display=0, col=0, busy=0, done=0, win=0, guess_cnt=0.
REQ-033 On the first clock edge after rst deasserts, the block shall behave normally.

Structure
REQ-034 The shared package wordle_pkg shall hold: the color constants (GREEN, YELLOW, GRAY, NONE), WORD_LEN=5, MAX_GUESSES=6, LETTER_W=5, SLOT_W=7 and the FSM state enumeration.
REQ-035 A combinational sub-module letter_scorer(letter, index, current_word -> color) shall implement REQ-022; guess_writer shall instantiate it once, addressed by the score index.

Verification
REQ-036 Target CRANE (2,17,0,13,4): add C,R,A,N,E then submit -> busy high for 5 cycles, then done pulse, all slots 01, win=1, state LOCK, later adds ignored.
REQ-037 Target CRANE, guess NACRE (13,0,2,17,4) -> slots 0-3 color 10, slot 4 color 01, win=0, guess_cnt=1, state SHOW.
REQ-038 Enter 3 letters, submit -> ignored; del twice -> col=1, slots 1-2 zero; del at col=0 -> no change; add with sw=27 -> ignored.
REQ-039 Same-cycle add+del at col=3 -> col=2 only; add during SCORE -> no effect on display or col.
REQ-040 Six non-winning guesses -> guess_cnt=6, state LOCK; rst asserted mid-SCORE -> all outputs zero asynchronously, without waiting for a clock edge.
